// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU operand/function select, condition-code register,
// branch/cmov condition evaluation and the E->M pipeline register.
module execute_stage #(
  parameter int          WIDTH = 64,
  parameter logic [3:0]  RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WIDTH-1:0] E_valC,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [WIDTH-1:0] E_valB,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic             m_exc,
  input  logic             W_exc,
  input  logic             M_stall,
  input  logic             M_bubble,
  output logic [WIDTH-1:0] e_valE,
  output logic [3:0]       e_dstE,
  output logic             e_Cnd,
  output logic [2:0]       cc,
  output logic [1:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_Cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM
);

  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OP    = 4'h6;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [1:0] F_ADD = 2'd0;
  localparam logic [1:0] F_SUB = 2'd1;
  localparam logic [1:0] F_AND = 2'd2;
  localparam logic [1:0] F_XOR = 2'd3;

  localparam logic [WIDTH-1:0] POS8 = WIDTH'(8);
  localparam logic [WIDTH-1:0] NEG8 = ~(WIDTH'(7));

  logic [WIDTH-1:0] w_aluA, w_aluB, w_result;
  logic [1:0]       w_alufun;
  logic             w_zf, w_sf, w_of, w_set_cc;
  logic             w_zc, w_sc, w_oc;

  logic [2:0]       r_cc;
  logic [1:0]       r_stat;
  logic [3:0]       r_icode;
  logic             r_cnd;
  logic [WIDTH-1:0] r_valE, r_valA;
  logic [3:0]       r_dstE, r_dstM;

  always_comb begin
    w_aluA = '0;
    w_aluB = '0;
    unique case (E_icode)
      I_RRMOV:                 w_aluA = E_valA;
      I_OP:                    begin w_aluA = E_valA; w_aluB = E_valB; end
      I_IRMOV:                 w_aluA = E_valC;
      I_RMMOV, I_MRMOV:        begin w_aluA = E_valC; w_aluB = E_valB; end
      I_CALL, I_PUSH:          begin w_aluA = NEG8;   w_aluB = E_valB; end
      I_RET, I_POP:            begin w_aluA = POS8;   w_aluB = E_valB; end
      default:                 ;
    endcase
  end

  // Undefined OP function codes fall back to add.
  assign w_alufun = (E_icode == I_OP && E_ifun <= 4'd3) ? E_ifun[1:0] : F_ADD;

  always_comb begin
    w_result = '0;
    w_of     = 1'b0;
    unique case (w_alufun)
      F_ADD: begin
        w_result = w_aluB + w_aluA;
        w_of = (w_aluA[WIDTH-1] == w_aluB[WIDTH-1]) && (w_result[WIDTH-1] != w_aluA[WIDTH-1]);
      end
      F_SUB: begin
        w_result = w_aluB - w_aluA;
        w_of = (w_aluA[WIDTH-1] != w_aluB[WIDTH-1]) && (w_result[WIDTH-1] != w_aluB[WIDTH-1]);
      end
      F_AND:   w_result = w_aluB & w_aluA;
      F_XOR:   w_result = w_aluB ^ w_aluA;
      default: ;
    endcase
  end

  assign w_zf     = (w_result == '0);
  assign w_sf     = w_result[WIDTH-1];
  assign w_set_cc = (E_icode == I_OP) && !m_exc && !W_exc;

  // Conditions read the stored flags, not the flags being produced this cycle.
  assign {w_zc, w_sc, w_oc} = r_cc;

  always_comb begin
    e_Cnd = 1'b0;
    unique case (E_ifun)
      4'd0:    e_Cnd = 1'b1;
      4'd1:    e_Cnd = (w_sc ^ w_oc) | w_zc;
      4'd2:    e_Cnd = w_sc ^ w_oc;
      4'd3:    e_Cnd = w_zc;
      4'd4:    e_Cnd = !w_zc;
      4'd5:    e_Cnd = !(w_sc ^ w_oc);
      4'd6:    e_Cnd = !(w_sc ^ w_oc) && !w_zc;
      default: e_Cnd = 1'b0;
    endcase
  end

  assign e_valE = w_result;
  assign e_dstE = (E_icode == I_RRMOV && !e_Cnd) ? RNONE : E_dstE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cc    <= 3'b100;
      r_stat  <= 2'd0;
      r_icode <= I_NOP;
      r_cnd   <= 1'b0;
      r_valE  <= '0;
      r_valA  <= '0;
      r_dstE  <= RNONE;
      r_dstM  <= RNONE;
    end else begin
      if (w_set_cc)
        r_cc <= {w_zf, w_sf, w_of};
      if (M_bubble) begin
        r_stat  <= 2'd0;
        r_icode <= I_NOP;
        r_cnd   <= 1'b0;
        r_valE  <= '0;
        r_valA  <= '0;
        r_dstE  <= RNONE;
        r_dstM  <= RNONE;
      end else if (!M_stall) begin
        r_stat  <= E_stat;
        r_icode <= E_icode;
        r_cnd   <= e_Cnd;
        r_valE  <= w_result;
        r_valA  <= E_valA;
        r_dstE  <= e_dstE;
        r_dstM  <= E_dstM;
      end
    end
  end

  assign cc      = r_cc;
  assign M_stat  = r_stat;
  assign M_icode = r_icode;
  assign M_Cnd   = r_cnd;
  assign M_valE  = r_valE;
  assign M_valA  = r_valA;
  assign M_dstE  = r_dstE;
  assign M_dstM  = r_dstM;

endmodule
